// File: rtl/vga_sync_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_sync_gen : raster timing generator (pixel tick, x/y, active, syncs)
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int PIPE_DLY = 0,
  parameter int CW       = 10
) (
  input  logic          i_CLK,
  input  logic          i_Rst,
  input  logic          i_En,
  output logic          o_pix_ce,
  output logic [CW-1:0] o_x_pos,
  output logic [CW-1:0] o_y_pos,
  output logic          o_active,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_HSync,
  output logic          o_VSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] C_V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] C_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] C_HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] C_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] C_VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] C_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL >= (1 << CW)) begin : g_chk_h
    $error("vga_sync_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (1 << CW)) begin : g_chk_v
    $error("vga_sync_gen: V_TOTAL does not fit in CW bits");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
    $error("vga_sync_gen: CLK_DIV out of range 1..16");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_chk_dly
    $error("vga_sync_gen: PIPE_DLY out of range 0..8");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          act_q, act_d;
  logic          lz_q, lz_d;
  logic          fz_q, fz_d;
  logic          started_q;
  logic          hs0_q, hs_d;
  logic          vs0_q, vs_d;
  logic          pix_ce;

  // Reset is gated in so no tick can be reported while the counters clear.
  assign pix_ce = i_En & ~i_Rst & (div_q == C_DIV_LAST);

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (i_En) begin
      div_d = (div_q == C_DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (pix_ce) begin
      if (x_q == C_H_LAST) begin
        x_d = '0;
        y_d = (y_q == C_V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    act_d = (x_d < C_H_ACT) && (y_d < C_V_ACT);
    lz_d  = (x_d == '0);
    fz_d  = (x_d == '0) && (y_d == '0);
    hs_d  = ((x_d >= C_HS_BEG) && (x_d < C_HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = ((y_d >= C_VS_BEG) && (y_d < C_VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge i_CLK) begin
    if (i_Rst) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      act_q     <= 1'b1;
      lz_q      <= 1'b1;
      fz_q      <= 1'b1;
      started_q <= 1'b0;
      hs0_q     <= ~SYNC_POL;
      vs0_q     <= ~SYNC_POL;
    end else if (i_En) begin
      div_q <= div_d;
      if (pix_ce) begin
        x_q       <= x_d;
        y_q       <= y_d;
        act_q     <= act_d;
        lz_q      <= lz_d;
        fz_q      <= fz_d;
        started_q <= 1'b1;
        hs0_q     <= hs_d;
        vs0_q     <= vs_d;
      end
    end
  end

  if (PIPE_DLY > 0) begin : g_dly
    logic [PIPE_DLY-1:0] hsd_q;
    logic [PIPE_DLY-1:0] vsd_q;

    always_ff @(posedge i_CLK) begin
      if (i_Rst) begin
        hsd_q <= {PIPE_DLY{~SYNC_POL}};
        vsd_q <= {PIPE_DLY{~SYNC_POL}};
      end else if (pix_ce) begin
        hsd_q <= PIPE_DLY'({hsd_q, hs0_q});
        vsd_q <= PIPE_DLY'({vsd_q, vs0_q});
      end
    end

    assign o_HSync = hsd_q[PIPE_DLY-1];
    assign o_VSync = vsd_q[PIPE_DLY-1];
  end else begin : g_nodly
    assign o_HSync = hs0_q;
    assign o_VSync = vs0_q;
  end

  // Position (0,0) is active, but o_active stays low until the first tick.
  assign o_active      = act_q & (started_q | pix_ce);
  assign o_pix_ce      = pix_ce;
  assign o_x_pos       = x_q;
  assign o_y_pos       = y_q;
  assign o_line_start  = pix_ce & lz_q;
  assign o_frame_start = pix_ce & fz_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// tb_vga_sync_gen : directed bench; default 640x480 instance plus a tiny
// raster (16x8, CLK_DIV=4, PIPE_DLY=3, active-high syncs) for frame wrap.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic       pce_a, act_a, ls_a, fs_a, hs_a, vs_a;
  logic [9:0] x_a, y_a;
  logic       pce_b, act_b, ls_b, fs_b, hs_b, vs_b;
  logic [5:0] x_b, y_b;

  int n_tests = 0;
  int n_fail  = 0;

  vga_sync_gen u_dut_a (
    .i_CLK(clk), .i_Rst(rst_a), .i_En(en_a),
    .o_pix_ce(pce_a), .o_x_pos(x_a), .o_y_pos(y_a), .o_active(act_a),
    .o_line_start(ls_a), .o_frame_start(fs_a), .o_HSync(hs_a), .o_VSync(vs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CLK_DIV(4), .PIPE_DLY(3), .CW(6)
  ) u_dut_b (
    .i_CLK(clk), .i_Rst(rst_b), .i_En(en_b),
    .o_pix_ce(pce_b), .o_x_pos(x_b), .o_y_pos(y_b), .o_active(act_b),
    .o_line_start(ls_b), .o_frame_start(fs_b), .o_HSync(hs_b), .o_VSync(vs_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt, vcnt, nls, nfs, npce, n, bad;
    bit   found;
    logic h0, h1, h2, h3, a0, a1;

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_x", x_a, 0);
    check("a_rst_y", y_a, 0);
    check("a_rst_pce", pce_a, 0);
    check("a_rst_active", act_a, 0);
    check("a_rst_fs", fs_a, 0);
    check("a_rst_hs", hs_a, 1);
    check("a_rst_vs", vs_a, 1);
    rst_a = 1'b0;

    @(negedge clk);
    check("a_first_pce", pce_a, 1);
    check("a_first_fs", fs_a, 1);
    check("a_first_ls", ls_a, 1);
    check("a_first_active", act_a, 1);

    // One full line at one pixel per clock.
    cnt = 0; nls = 0; npce = 0; vcnt = 0;
    h0 = 1'bx; h1 = 1'bx; h2 = 1'bx; h3 = 1'bx; a0 = 1'bx; a1 = 1'bx;
    for (int i = 0; i < 800; i++) begin
      if (!hs_a) cnt++;
      if (!vs_a) vcnt++;
      if (ls_a)  nls++;
      if (pce_a) npce++;
      if (x_a == 10'd655) h0 = hs_a;
      if (x_a == 10'd656) h1 = hs_a;
      if (x_a == 10'd751) h2 = hs_a;
      if (x_a == 10'd752) h3 = hs_a;
      if (x_a == 10'd639) a0 = act_a;
      if (x_a == 10'd640) a1 = act_a;
      @(negedge clk);
    end
    check("a_hs_low_cycles", cnt, 96);
    check("a_vs_low_cycles", vcnt, 0);
    check("a_line_starts", nls, 1);
    check("a_pce_count", npce, 800);
    check("a_hs_x655", h0, 1);
    check("a_hs_x656", h1, 0);
    check("a_hs_x751", h2, 0);
    check("a_hs_x752", h3, 1);
    check("a_act_x639", a0, 1);
    check("a_act_x640", a1, 0);
    check("a_wrap_x", x_a, 0);
    check("a_wrap_y", y_a, 1);
    check("a_wrap_ls", ls_a, 1);
    check("a_wrap_fs", fs_a, 0);

    // Reset in the middle of a line.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (pce_a && x_a == 10'd300) found = 1'b1;
      else @(negedge clk);
    end
    check("a_find_x300", found, 1);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_mrst_x", x_a, 0);
    check("a_mrst_y", y_a, 0);
    check("a_mrst_pce", pce_a, 0);
    check("a_mrst_hs", hs_a, 1);
    check("a_mrst_vs", vs_a, 1);
    rst_a = 1'b0;
    @(negedge clk);
    check("a_mrst_fs", fs_a, 1);
    check("a_mrst_tick_x", x_a, 0);

    // Small raster: reset values with active-high syncs.
    check("b_rst_x", x_b, 0);
    check("b_rst_pce", pce_b, 0);
    check("b_rst_active", act_b, 0);
    check("b_rst_hs", hs_b, 0);
    check("b_rst_vs", vs_b, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n++;
      if (pce_b) found = 1'b1;
    end
    check("b_first_tick_lat", n, 4);
    check("b_first_fs", fs_b, 1);
    check("b_first_y", y_b, 0);

    // One full frame: 128 pixels x 4 clocks.
    cnt = 0; vcnt = 0; nls = 0; nfs = 0; npce = 0;
    h0 = 1'bx; h1 = 1'bx; h2 = 1'bx; a0 = 1'bx; a1 = 1'bx;
    for (int i = 0; i < 512; i++) begin
      if (hs_b)  cnt++;
      if (vs_b)  vcnt++;
      if (ls_b)  nls++;
      if (fs_b)  nfs++;
      if (pce_b) npce++;
      if (pce_b && y_b == 6'd0 && x_b == 6'd12) h0 = hs_b;
      if (pce_b && y_b == 6'd0 && x_b == 6'd13) h1 = hs_b;
      if (pce_b && y_b == 6'd0 && x_b == 6'd15) h2 = hs_b;
      if (pce_b && y_b == 6'd5 && x_b == 6'd2)  a0 = vs_b;
      if (pce_b && y_b == 6'd5 && x_b == 6'd3)  a1 = vs_b;
      @(negedge clk);
    end
    check("b_pce_count", npce, 128);
    check("b_line_starts", nls, 8);
    check("b_frame_starts", nfs, 1);
    check("b_hs_high_cycles", cnt, 96);
    check("b_vs_high_cycles", vcnt, 128);
    check("b_hs_dly_x12", h0, 0);
    check("b_hs_dly_x13", h1, 1);
    check("b_hs_dly_x15", h2, 1);
    check("b_vs_dly_x2", a0, 0);
    check("b_vs_dly_x3", a1, 1);
    check("b_wrap_fs", fs_b, 1);
    check("b_wrap_x", x_b, 0);

    // Freeze right after the last pixel of the frame.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (pce_b && x_b == 6'd15 && y_b == 6'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("b_find_last", found, 1);
    @(posedge clk);
    #1;
    en_b = 1'b0;
    npce = 0; bad = 0; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pce_b || ls_b || fs_b) npce++;
      if (x_b != 6'd0 || y_b != 6'd0) bad++;
      if (hs_b || vs_b) cnt++;
    end
    check("b_hold_pulses", npce, 0);
    check("b_hold_pos", bad, 0);
    check("b_hold_sync", cnt, 0);
    en_b = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n++;
      if (pce_b) found = 1'b1;
    end
    check("b_resume_lat", n, 3);
    check("b_resume_x", x_b, 0);
    check("b_resume_y", y_b, 0);
    check("b_resume_fs", fs_b, 1);

    // Reset while both syncs are asserted mid-frame.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (pce_b && x_b == 6'd14 && y_b == 6'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("b_find_14_5", found, 1);
    check("b_pre_rst_hs", hs_b, 1);
    check("b_pre_rst_vs", vs_b, 1);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("b_mrst_x", x_b, 0);
    check("b_mrst_y", y_b, 0);
    check("b_mrst_hs", hs_b, 0);
    check("b_mrst_vs", vs_b, 0);
    rst_b = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n++;
      if (pce_b) found = 1'b1;
    end
    check("b_mrst_lat", n, 4);
    check("b_mrst_fs", fs_b, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
